// File: rtl/lcd_txn_pkg.sv
// -----------------------------------------------------------------------------
// lcd_txn_pkg
// Shared types for the LCD transaction path (arbiter, fifo_to_lcd_adapter,
// hd44780 glue).
//   LCD_TXN_W   : width of one LCD transaction word {rs, data[7:0]}
//   lcd_txn_t   : structured view of that word
//   arb_state_t : packet-lock arbiter state
//   wrap_add    : (a + b) mod n for operands already in 0..n-1, used for
//                 round-robin pointer arithmetic without a divider
// -----------------------------------------------------------------------------
package lcd_txn_pkg;

    localparam int LCD_TXN_W = 9;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_txn_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // Operands are both below n, so a single conditional subtract suffices.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/lcd_txn_arbiter_if.sv
// -----------------------------------------------------------------------------
// lcd_txn_arbiter_if
// Bundles the requester handshake and the sync_fifo write port seen by the
// LCD transaction arbiter.
//   req_valid[N_REQ]        : per-requester beat valid
//   req_data[N_REQ*TXN_W]   : requester i at bits [i*TXN_W +: TXN_W]
//   req_last[N_REQ]         : beat closes the requester's packet
//   req_ready[N_REQ]        : beat accepted when valid && ready
//   fifo_full               : sync_fifo full flag
//   fifo_wr_en / fifo_din   : sync_fifo write strobe and data
// Modports:
//   slave  : the arbiter (consumes requests, drives the FIFO write port)
//   master : the environment (requesters + FIFO)
// -----------------------------------------------------------------------------
interface lcd_txn_arbiter_if
    import lcd_txn_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int TXN_W = LCD_TXN_W
);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*TXN_W-1:0] req_data;
    logic [N_REQ-1:0]       req_last;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [TXN_W-1:0]       fifo_din;

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  fifo_full,
        output req_ready,
        output fifo_wr_en,
        output fifo_din
    );

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output fifo_full,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_din
    );

endinterface

// File: rtl/lcd_txn_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: finds the first set bit of req at or
// above index ptr, wrapping from N-1 back to 0.
//   req[N] : request vector
//   ptr    : search start index (must be < N)
//   any    : at least one request is set
//   idx    : chosen index (0 when any is low)
// Structure: rotate req so bit ptr lands at position 0, priority-encode the
// lowest set bit, then add ptr back (mod N).
// -----------------------------------------------------------------------------
module rr_pick
    import lcd_txn_pkg::*;
#(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);

    logic [N-1:0]        rot;
    logic [N-1:0][N-1:0] sel;
    int                  first_rot;

    // rot[gi] = req[(gi + ptr) mod N], built as an AND-OR mux so no index
    // arithmetic is needed on the vector select.
    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            for (gj = 0; gj < N; gj++) begin : g_src
                assign sel[gi][gj] = req[gj] && (wrap_add(gi, int'(ptr), N) == gj);
            end
            assign rot[gi] = |sel[gi];
        end
    endgenerate

    always_comb begin
        first_rot = 0;
        // Scan downwards so the lowest set rotated bit is the one left standing.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                first_rot = i;
            end
        end
        any = |req;
        idx = any ? W'(wrap_add(first_rot, int'(ptr), N)) : '0;
    end

endmodule

// File: rtl/lcd_txn_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_txn_arbiter
// Shares the single LCD transaction FIFO between N_REQ requesters with
// round-robin arbitration at packet granularity. A granted requester keeps
// the FIFO until it transfers a beat marked last, so multi-word sequences
// (cursor command + characters) stay contiguous. A requester that stalls for
// TIMEOUT_CYCLES idle cycles loses its lock; a full FIFO never counts as a
// stall.
// Ports:
//   MAX10_CLK1_50 : 50 MHz system clock
//   rst_n         : asynchronous active-low reset
//   bus           : requester handshake + sync_fifo write port (slave side)
//   grant_id      : current / last granted requester
//   busy          : a packet lock is held
//   timeout_pulse : one-cycle strobe when a lock is revoked by timeout
// -----------------------------------------------------------------------------
module lcd_txn_arbiter
    import lcd_txn_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int TXN_W          = LCD_TXN_W,
    parameter int TIMEOUT_CYCLES = 5000000,
    localparam int GID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W         = $clog2(TIMEOUT_CYCLES)
) (
    input  logic              MAX10_CLK1_50,
    input  logic              rst_n,
    lcd_txn_arbiter_if.slave  bus,
    output logic [GID_W-1:0]  grant_id,
    output logic              busy,
    output logic              timeout_pulse
);

    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state_q, state_d;
    logic [GID_W-1:0] grant_q, grant_d;
    logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q, timeout_d;

    logic             pick_any;
    logic [GID_W-1:0] pick_idx;
    logic [GID_W-1:0] ptr_after_grant;

    logic             g_valid;
    logic             g_last;
    logic [TXN_W-1:0] g_data;

    logic             wr_en;
    logic [TXN_W-1:0] din;

    logic [TXN_W-1:0] beat [N_REQ];

    // -------------------------------------------------------------------------
    // Per-requester beat slices and ready strobes. Only the granted lane can
    // see ready, and only while the FIFO has room.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign beat[gi] = bus.req_data[gi*TXN_W +: TXN_W];
            assign bus.req_ready[gi] = (state_q == ARB_LOCKED)
                                       && (grant_q == GID_W'(gi))
                                       && !bus.fifo_full;
        end
    endgenerate

    rr_pick #(
        .N (N_REQ),
        .W (GID_W)
    ) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign ptr_after_grant = GID_W'(wrap_add(int'(grant_q), 1, N_REQ));

    // Granted-lane mux.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == GID_W'(i)) begin
                g_valid = bus.req_valid[i];
                g_last  = bus.req_last[i];
                g_data  = beat[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;
        timeout_d   = 1'b0;
        wr_en       = 1'b0;
        din         = '0;
        busy        = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                stall_cnt_d = '0;
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ARB_LOCKED;
                end
            end

            ARB_LOCKED: begin
                busy = 1'b1;
                if (bus.fifo_full) begin
                    // Downstream backpressure is not the requester's fault.
                    stall_cnt_d = '0;
                end else if (g_valid) begin
                    wr_en       = 1'b1;
                    din         = g_data;
                    stall_cnt_d = '0;
                    if (g_last) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = ptr_after_grant;
                    end
                end else if (stall_cnt_q == STALL_LAST) begin
                    // This is stall cycle number TIMEOUT_CYCLES: revoke.
                    state_d     = ARB_IDLE;
                    rr_ptr_d    = ptr_after_grant;
                    timeout_d   = 1'b1;
                    stall_cnt_d = '0;
                end else if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Reset forces state_q to IDLE immediately, which already drives the
    // write strobe, data and ready lines to zero.
    assign bus.fifo_wr_en = wr_en;
    assign bus.fifo_din   = din;
    assign grant_id       = grant_q;
    assign timeout_pulse  = timeout_q;

endmodule

// File: tb/tb_lcd_txn_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lcd_txn_arbiter
// Self-checking bench for lcd_txn_arbiter (N_REQ=3, TIMEOUT_CYCLES=8).
// Requester beats live in a queue; expected FIFO words {grant_id, din} are
// pushed in the order the arbiter must write them and popped whenever the
// DUT strobes fifo_wr_en.
// -----------------------------------------------------------------------------
module tb_lcd_txn_arbiter;
    import lcd_txn_pkg::*;

    localparam int N = 3;
    localparam int W = LCD_TXN_W;
    localparam int T = 8;

    typedef struct {
        int         req;
        logic [8:0] data;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_pulse;

    always #10 clk = ~clk;

    lcd_txn_arbiter_if #(.N_REQ(N), .TXN_W(W)) bus ();

    lcd_txn_arbiter #(
        .N_REQ          (N),
        .TXN_W          (W),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    beat_t       beats[$];
    logic [10:0] exp_q[$];
    logic        full_ctl = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h @%0t", tag, got, $time);
        end
    endtask

    task automatic add_beat(input int r, input logic [8:0] d, input logic last, input bit expect_wr);
        beat_t b;
        b.req  = r;
        b.data = d;
        b.last = last;
        beats.push_back(b);
        if (expect_wr) exp_q.push_back({2'(r), d});
    endtask

    task automatic drive();
        bit found;
        bus.fifo_full = full_ctl;
        for (int i = 0; i < N; i++) begin
            found = 1'b0;
            bus.req_valid[i]        = 1'b0;
            bus.req_last[i]         = 1'b0;
            bus.req_data[i*W +: W]  = '0;
            for (int k = 0; k < beats.size(); k++) begin
                if (!found && beats[k].req == i) begin
                    found = 1'b1;
                    bus.req_valid[i]       = 1'b1;
                    bus.req_last[i]        = beats[k].last;
                    bus.req_data[i*W +: W] = beats[k].data;
                end
            end
        end
    endtask

    task automatic monitor();
        logic [10:0] e;
        if (bus.fifo_wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_wr", {21'd0, grant_id, bus.fifo_din}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_word", {21'd0, grant_id, bus.fifo_din}, {21'd0, e});
            end
        end else begin
            check_eq("din_zero_no_wr", {23'd0, bus.fifo_din}, 32'd0);
        end
        check_eq("ready_onehot", ($countones(bus.req_ready) <= 1) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                for (int k = 0; k < beats.size(); k++) begin
                    if (beats[k].req == i) begin
                        beats.delete(k);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        monitor();
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while ((beats.size() != 0 || exp_q.size() != 0 || busy) && c < budget) begin
            cycle();
            c++;
        end
        check_eq("drain_in_budget", (c < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int start_wr;

        // ---------------- reset state ----------------
        drive();
        #1;
        check_eq("rst_grant", {30'd0, grant_id}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_tmo", {31'd0, timeout_pulse}, 32'd0);
        check_eq("rst_wr_en", {31'd0, bus.fifo_wr_en}, 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;

        // ---------------- single packet ----------------
        add_beat(0, 9'h080, 1'b0, 1'b1);
        add_beat(0, 9'h141, 1'b0, 1'b1);
        add_beat(0, 9'h142, 1'b1, 1'b1);
        cycle();
        check_eq("t1_grant_cycle_busy", {31'd0, busy}, 32'd0);
        check_eq("t1_grant_cycle_no_wr", {31'd0, bus.fifo_wr_en}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("t1_wr_consecutive", {31'd0, bus.fifo_wr_en}, 32'd1);
            check_eq("t1_busy", {31'd0, busy}, 32'd1);
        end
        cycle();
        check_eq("t1_busy_drop", {31'd0, busy}, 32'd0);
        check_eq("t1_no_wr_after_last", {31'd0, bus.fifo_wr_en}, 32'd0);
        // rr_ptr should now be 1: req1 must beat req0.
        add_beat(0, 9'h0A0, 1'b1, 1'b0);
        add_beat(1, 9'h1B0, 1'b1, 1'b1);
        exp_q.push_back({2'd0, 9'h0A0});
        wait_drain(40);

        // ---------------- contention from reset ----------------
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            for (int r = 0; r < N; r++) begin
                add_beat(r, 9'(16 * r + 4 * rep + 1), 1'b0, 1'b1);
                add_beat(r, 9'(16 * r + 4 * rep + 2), 1'b1, 1'b1);
            end
            wait_drain(60);
        end

        // ---------------- backpressure ----------------
        add_beat(0, 9'h0D1, 1'b0, 1'b1);
        add_beat(0, 9'h0D2, 1'b0, 1'b1);
        add_beat(0, 9'h0D3, 1'b1, 1'b1);
        start_wr = wr_count;
        n = 0;
        while (wr_count == start_wr && n < 20) begin
            cycle();
            n++;
        end
        check_eq("t3_first_beat_seen", (wr_count > start_wr) ? 32'd1 : 32'd0, 32'd1);
        full_ctl = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check_eq("t3_full_ready", {29'd0, bus.req_ready}, 32'd0);
            check_eq("t3_full_wr_en", {31'd0, bus.fifo_wr_en}, 32'd0);
            check_eq("t3_full_no_tmo", {31'd0, timeout_pulse}, 32'd0);
        end
        full_ctl = 1'b0;
        cycle();
        check_eq("t3_resume", {31'd0, bus.fifo_wr_en}, 32'd1);
        wait_drain(40);

        // ---------------- timeout ----------------
        add_beat(1, 9'h155, 1'b0, 1'b1);
        add_beat(2, 9'h0C2, 1'b1, 1'b1);
        cycle();
        cycle();
        check_eq("t4_beat_written", {31'd0, bus.fifo_wr_en}, 32'd1);
        check_eq("t4_grant1", {30'd0, grant_id}, 32'd1);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!timeout_pulse && n < 30);
        check_eq("t4_tmo_latency", 32'(n), 32'd9);
        check_eq("t4_idle_on_tmo", {31'd0, busy}, 32'd0);
        cycle();
        check_eq("t4_pulse_one_cycle", {31'd0, timeout_pulse}, 32'd0);
        check_eq("t4_req2_granted", {30'd0, grant_id}, 32'd2);
        check_eq("t4_req2_busy", {31'd0, busy}, 32'd1);
        wait_drain(40);

        // Move rr_ptr to 1 so a reset that fails to clear it is visible.
        add_beat(0, 9'h0E0, 1'b1, 1'b1);
        wait_drain(40);

        // ---------------- reset mid-packet ----------------
        add_beat(2, 9'h111, 1'b0, 1'b1);
        add_beat(2, 9'h112, 1'b0, 1'b0);
        add_beat(2, 9'h113, 1'b0, 1'b0);
        add_beat(2, 9'h114, 1'b1, 1'b0);
        cycle();
        cycle();
        @(negedge clk);
        drive();
        #1;
        check_eq("t5_beat2_presented", {21'd0, grant_id, bus.fifo_din}, {21'd0, 2'd2, 9'h112});
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_wr_en", {31'd0, bus.fifo_wr_en}, 32'd0);
        check_eq("t5_rst_din", {23'd0, bus.fifo_din}, 32'd0);
        check_eq("t5_rst_ready", {29'd0, bus.req_ready}, 32'd0);
        check_eq("t5_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_rst_grant", {30'd0, grant_id}, 32'd0);
        beats.delete();
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("t5_post_rst_grant", {30'd0, grant_id}, 32'd0);
            check_eq("t5_post_rst_no_wr", {31'd0, bus.fifo_wr_en}, 32'd0);
        end
        // rr_ptr must be back at 0: req0 wins over req2.
        add_beat(0, 9'h0F0, 1'b1, 1'b1);
        add_beat(2, 9'h0F2, 1'b1, 1'b1);
        wait_drain(40);

        check_eq("final_exp_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
